// File: rtl/udma_tx_req_arbiter.sv
// Round-robin arbiter sharing one uDMA TX channel between N_REQ requesters.
// Grant order is kept in a tag FIFO so returning beats are steered to their issuer.
//
// state     | meaning
// ST_IDLE   | no selection held; round-robin search from rr_ptr each cycle
// ST_LOCKED | request presented but not granted; selection held at lock_idx
module udma_tx_req_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_OUTST = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_i,
    input  logic [2*N_REQ-1:0]           datasize_i,
    output logic [N_REQ-1:0]             gnt_o,
    output logic [31:0]                  data_o,
    output logic [N_REQ-1:0]             valid_o,
    input  logic [N_REQ-1:0]             ready_i,
    output logic                         data_tx_req_o,
    input  logic                         data_tx_gnt_i,
    output logic [1:0]                   data_tx_datasize_o,
    input  logic [31:0]                  data_tx_i,
    input  logic                         data_tx_valid_i,
    output logic                         data_tx_ready_o,
    output logic [$clog2(MAX_OUTST):0]   outst_o,
    output logic                         err_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [IDX_W-1:0]   lock_idx, lock_idx_d;
    logic [IDX_W-1:0]   tag_mem [MAX_OUTST];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [CNT_W-1:0]   count;

    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   win_idx, sel_idx, head;
    logic               any_req, tx_req, grant, push, pop, fifo_full, fifo_empty;

    assign fifo_full  = (count == CNT_W'(MAX_OUTST));
    assign fifo_empty = (count == '0);
    assign head       = tag_mem[rd_ptr];

    // Walk from the lowest priority upward so the highest-priority hit wins.
    always_comb begin
        win_idx = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (req_i[cand[IDX_W-1:0]]) begin
                win_idx = cand[IDX_W-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx;
        rr_ptr_d   = rr_ptr;
        sel_idx    = win_idx;
        tx_req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_req = any_req && !fifo_full;
                if (tx_req && !data_tx_gnt_i) begin
                    state_d    = ST_LOCKED;
                    lock_idx_d = win_idx;
                end
            end
            ST_LOCKED: begin
                sel_idx = lock_idx;
                tx_req  = req_i[lock_idx];
                if (!tx_req || data_tx_gnt_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst_i)
            tx_req = 1'b0;
        grant = tx_req && data_tx_gnt_i;
        if (grant)
            rr_ptr_d = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end

    always_comb begin
        gnt_o           = '0;
        valid_o         = '0;
        data_tx_ready_o = 1'b0;
        pop             = 1'b0;
        if (grant)
            gnt_o[sel_idx] = 1'b1;
        if (!rst_i) begin
            if (!fifo_empty) begin
                valid_o[head]   = data_tx_valid_i;
                data_tx_ready_o = ready_i[head];
                pop             = data_tx_valid_i && ready_i[head];
            end else begin
                // Unexpected beat: accept and drop it so the uDMA does not stall.
                data_tx_ready_o = data_tx_valid_i;
            end
        end
    end

    assign push               = grant && !fifo_full;
    assign data_tx_req_o      = tx_req;
    assign data_tx_datasize_o = datasize_i[{sel_idx, 1'b0} +: 2];
    assign data_o             = data_tx_i;
    assign outst_o            = count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr   <= rr_ptr_d;
            lock_idx <= lock_idx_d;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (fifo_empty && data_tx_valid_i)
                err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            tag_mem[wr_ptr] <= sel_idx;
    end

endmodule

// File: tb/tb_udma_tx_req_arbiter.sv
// Directed bench for udma_tx_req_arbiter: grant order goes into a scoreboard
// queue and is popped and compared as beats return.
module tb_udma_tx_req_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  req_i;
    logic [7:0]  datasize_i;
    logic [3:0]  gnt_o;
    logic [31:0] data_o;
    logic [3:0]  valid_o;
    logic [3:0]  ready_i;
    logic        data_tx_req_o;
    logic        data_tx_gnt_i;
    logic [1:0]  data_tx_datasize_o;
    logic [31:0] data_tx_i;
    logic        data_tx_valid_i;
    logic        data_tx_ready_o;
    logic [2:0]  outst_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    // datasize of requester i is DS[2i+1:2i]: r0=1, r1=2, r2=3, r3=0
    logic [7:0] ds_tab = {2'd0, 2'd3, 2'd2, 2'd1};

    udma_tx_req_arbiter #(.N_REQ(4), .MAX_OUTST(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .datasize_i(datasize_i),
        .gnt_o(gnt_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .data_tx_req_o(data_tx_req_o), .data_tx_gnt_i(data_tx_gnt_i),
        .data_tx_datasize_o(data_tx_datasize_o), .data_tx_i(data_tx_i),
        .data_tx_valid_i(data_tx_valid_i), .data_tx_ready_o(data_tx_ready_o),
        .outst_o(outst_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] ds_of(input int i);
        return ds_tab[2*i +: 2];
    endfunction

    task automatic grant_step(input string tag, input logic [3:0] req, input int w);
        req_i         = req;
        data_tx_gnt_i = 1'b1;
        #2;
        chk({tag, "_req"}, 32'(data_tx_req_o), 32'd1);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'(4'b1 << w));
        chk({tag, "_ds"}, 32'(data_tx_datasize_o), 32'(ds_of(w)));
        exp_q.push_back(w);
        tick();
        req_i         = '0;
        data_tx_gnt_i = 1'b0;
    endtask

    task automatic ret_beat(input string tag, input logic [31:0] d);
        int e;
        data_tx_valid_i = 1'b1;
        data_tx_i       = d;
        #2;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(valid_o), 32'(4'b1 << e));
            chk({tag, "_data"}, data_o, d);
            chk({tag, "_ready"}, 32'(data_tx_ready_o), 32'd1);
        end
        tick();
        data_tx_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; req_i = 4'b1111; datasize_i = ds_tab; ready_i = 4'b1111;
        data_tx_gnt_i = 1'b1; data_tx_i = '0; data_tx_valid_i = 1'b1;

        // Outputs forced low during reset
        #2;
        chk("rst_req", 32'(data_tx_req_o), 32'd0);
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_ready", 32'(data_tx_ready_o), 32'd0);
        tick();
        tick();
        chk("rst_outst", 32'(outst_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        req_i = '0; data_tx_gnt_i = 1'b0; data_tx_valid_i = 1'b0;
        rst_i = 1'b0;

        // Fairness: all requesting, every grant returned the next cycle
        for (int i = 0; i < 6; i++) begin
            int e;
            req_i         = 4'b1111;
            data_tx_gnt_i = 1'b1;
            data_tx_valid_i = (exp_q.size() > 0);
            data_tx_i     = 32'h100 + 32'(i);
            #2;
            chk("fair_outst", 32'(outst_o), 32'(exp_q.size()));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("fair_valid", 32'(valid_o), 32'(4'b1 << e));
                chk("fair_data", data_o, 32'h100 + 32'(i));
            end
            chk("fair_gnt", 32'(gnt_o), 32'(4'b1 << (i % 4)));
            chk("fair_ds", 32'(data_tx_datasize_o), 32'(ds_of(i % 4)));
            exp_q.push_back(i % 4);
            tick();
        end
        req_i = '0; data_tx_gnt_i = 1'b0;
        ret_beat("fair_drain", 32'h1FF);

        // Lock: rr_ptr=2, req 0011 -> winner 0, held while bit1 drops and bit2 rises
        req_i = 4'b0011;
        #2;
        chk("lock_req0", 32'(data_tx_req_o), 32'd1);
        chk("lock_ds0", 32'(data_tx_datasize_o), 32'(ds_of(0)));
        tick();
        req_i = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            #2;
            chk("lock_ds_hold", 32'(data_tx_datasize_o), 32'(ds_of(0)));
            chk("lock_gnt_low", 32'(gnt_o), 32'd0);
            tick();
        end
        grant_step("lock_grant", 4'b0101, 0);

        // Locked requester withdraws: no request while locked, then IDLE re-arbitrates
        req_i = 4'b0100;
        tick();
        req_i = 4'b1000;
        #2;
        chk("drop_req", 32'(data_tx_req_o), 32'd0);
        tick();
        #2;
        chk("drop_rearb_req", 32'(data_tx_req_o), 32'd1);
        chk("drop_rearb_ds", 32'(data_tx_datasize_o), 32'(ds_of(3)));
        chk("drop_err", 32'(err_o), 32'd0);
        req_i = '0;
        ret_beat("lock_ret", 32'h55);

        // Ordering: rr_ptr=1, grants 2,0,3 back-to-back
        grant_step("ord_g2", 4'b0100, 2);
        grant_step("ord_g0", 4'b0001, 0);
        grant_step("ord_g3", 4'b1000, 3);
        #2;
        chk("ord_outst", 32'(outst_o), 32'd3);
        ret_beat("ord_a", 32'hA);
        ret_beat("ord_b", 32'hB);
        ret_beat("ord_c", 32'hC);

        // Full and backpressure: rr_ptr=0
        grant_step("full_g0", 4'b1111, 0);
        grant_step("full_g1", 4'b1111, 1);
        grant_step("full_g2", 4'b1111, 2);
        grant_step("full_g3", 4'b1111, 3);
        req_i = 4'b0010; data_tx_gnt_i = 1'b1;
        ready_i = 4'b1110; data_tx_valid_i = 1'b1; data_tx_i = 32'h77;
        #2;
        chk("full_req", 32'(data_tx_req_o), 32'd0);
        chk("full_outst", 32'(outst_o), 32'd4);
        chk("bp_ready", 32'(data_tx_ready_o), 32'd0);
        chk("bp_valid", 32'(valid_o), 32'b0001);
        tick();
        ready_i = 4'b1111;
        #2;
        chk("full_hold_outst", 32'(outst_o), 32'd4);
        chk("full_pop_req", 32'(data_tx_req_o), 32'd0);
        chk("full_pop_ready", 32'(data_tx_ready_o), 32'd1);
        void'(exp_q.pop_front());
        tick();
        data_tx_valid_i = 1'b0;
        grant_step("full_after_pop", 4'b0010, 1);
        ret_beat("full_r1", 32'h201);
        ret_beat("full_r2", 32'h202);
        ret_beat("full_r3", 32'h203);
        ret_beat("full_r4", 32'h204);

        // Protocol error: beat with empty FIFO
        data_tx_valid_i = 1'b1; ready_i = 4'b0000; data_tx_i = 32'hDEAD;
        #2;
        chk("err_ready", 32'(data_tx_ready_o), 32'd1);
        chk("err_valid", 32'(valid_o), 32'd0);
        tick();
        data_tx_valid_i = 1'b0; ready_i = 4'b1111;
        chk("err_set", 32'(err_o), 32'd1);
        tick();
        chk("err_held", 32'(err_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("err_clr", 32'(err_o), 32'd0);

        // Reset mid-operation: two outstanding, rr_ptr moved to 2
        grant_step("mid_g0", 4'b1111, 0);
        grant_step("mid_g1", 4'b1111, 1);
        rst_i = 1'b1; req_i = 4'b1111; data_tx_gnt_i = 1'b1; data_tx_valid_i = 1'b1;
        #2;
        chk("mid_rst_gnt", 32'(gnt_o), 32'd0);
        chk("mid_rst_valid", 32'(valid_o), 32'd0);
        chk("mid_rst_ready", 32'(data_tx_ready_o), 32'd0);
        tick();
        rst_i = 1'b0; data_tx_valid_i = 1'b0;
        exp_q.delete();
        chk("mid_outst", 32'(outst_o), 32'd0);
        grant_step("mid_first", 4'b1111, 0);
        ret_beat("mid_ret", 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
